// File: rtl/useq_host_bridge_if.sv
// rtl/useq_host_bridge_if.sv - host byte-stream rx/tx handshake bundle for the useq bridge
interface useq_host_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/useq_host_bridge.sv
// rtl/useq_host_bridge.sv - host command parser, program RAM owner and core FIFO port driver for useq
module useq_host_bridge #(
  parameter logic [7:0] ACK_BYTE = 8'h4B,
  parameter logic [7:0] ERR_BYTE = 8'h21,
  parameter logic [7:0] UNK_BYTE = 8'h3F
) (
  input  logic                  clk,
  input  logic                  rst_n,
  useq_host_bridge_if.slave     host,
  output logic                  core_rst_n,
  input  logic [7:0]            core_mem_addr,
  output logic [7:0]            core_mem_data,
  output logic                  fifo_write,
  output logic [7:0]            fifo_wdata,
  output logic                  fifo_read,
  input  logic [7:0]            fifo_rdata,
  input  logic                  fifo_empty
);

  typedef enum logic [2:0] {IDLE, L_ADDR, L_CNT, L_DATA, W_DATA, R_WAIT, R_CAP, TX} state_t;

  state_t     state, state_nx;
  logic       halted, halted_nx;
  logic [7:0] addr, addr_nx;
  logic [8:0] remaining, remaining_nx;
  logic [7:0] tx_data_q, tx_data_nx;
  logic [7:0] fifo_wdata_nx;
  logic       fifo_write_nx, fifo_read_nx;
  logic       fire, ram_we;
  logic [7:0] ram [256];

  assign host.rx_ready = (state == IDLE) || (state == L_ADDR) || (state == L_CNT) ||
                         (state == L_DATA) || (state == W_DATA);
  assign fire          = host.rx_valid & host.rx_ready;
  assign host.tx_valid = (state == TX);
  assign host.tx_data  = tx_data_q;
  assign core_mem_data = ram[core_mem_addr];

  always_comb begin
    state_nx      = state;
    halted_nx     = halted;
    addr_nx       = addr;
    remaining_nx  = remaining;
    tx_data_nx    = tx_data_q;
    fifo_wdata_nx = fifo_wdata;
    fifo_write_nx = 1'b0;
    fifo_read_nx  = 1'b0;
    ram_we        = 1'b0;
    case (state)
      IDLE: if (fire) begin
        case (host.rx_data)
          8'h4C: begin halted_nx = 1'b1; state_nx = L_ADDR; end
          8'h47: begin halted_nx = 1'b0; tx_data_nx = ACK_BYTE; state_nx = TX; end
          8'h48: begin halted_nx = 1'b1; tx_data_nx = ACK_BYTE; state_nx = TX; end
          8'h57: begin
            if (halted) begin tx_data_nx = ERR_BYTE; state_nx = TX; end
            else        state_nx = W_DATA;
          end
          8'h52: begin
            if (halted)          begin tx_data_nx = ERR_BYTE; state_nx = TX; end
            else if (fifo_empty) begin tx_data_nx = 8'h00;    state_nx = TX; end
            else                 begin fifo_read_nx = 1'b1;   state_nx = R_WAIT; end
          end
          8'h53:   begin tx_data_nx = {6'b0, halted, fifo_empty}; state_nx = TX; end
          default: begin tx_data_nx = UNK_BYTE; state_nx = TX; end
        endcase
      end
      L_ADDR: if (fire) begin addr_nx = host.rx_data; state_nx = L_CNT; end
      L_CNT: if (fire) begin
        // A count of zero means a full 256-byte image
        remaining_nx = (host.rx_data == 8'h00) ? 9'd256 : {1'b0, host.rx_data};
        state_nx     = L_DATA;
      end
      L_DATA: if (fire) begin
        ram_we       = 1'b1;
        addr_nx      = addr + 8'd1;
        remaining_nx = remaining - 9'd1;
        if (remaining == 9'd1) begin tx_data_nx = ACK_BYTE; state_nx = TX; end
      end
      W_DATA: if (fire) begin
        fifo_wdata_nx = host.rx_data;
        fifo_write_nx = 1'b1;
        tx_data_nx    = ACK_BYTE;
        state_nx      = TX;
      end
      R_WAIT: state_nx = R_CAP;
      R_CAP:  begin tx_data_nx = fifo_rdata; state_nx = TX; end
      TX:     if (host.tx_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      halted     <= 1'b1;
      core_rst_n <= 1'b0;
      addr       <= 8'h00;
      remaining  <= 9'd0;
      tx_data_q  <= 8'h00;
      fifo_write <= 1'b0;
      fifo_read  <= 1'b0;
      fifo_wdata <= 8'h00;
    end else begin
      state      <= state_nx;
      halted     <= halted_nx;
      core_rst_n <= ~halted;
      addr       <= addr_nx;
      remaining  <= remaining_nx;
      tx_data_q  <= tx_data_nx;
      fifo_write <= fifo_write_nx;
      fifo_read  <= fifo_read_nx;
      fifo_wdata <= fifo_wdata_nx;
    end
  end

  // Program RAM is deliberately outside the reset so a load survives rst_n
  always_ff @(posedge clk) begin
    if (ram_we) ram[addr] <= host.rx_data;
  end

endmodule

// File: tb/tb_useq_host_bridge.sv
// tb/tb_useq_host_bridge.sv - self-checking bench for useq_host_bridge
module tb_useq_host_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  useq_host_bridge_if bus();
  logic       core_rst_n;
  logic [7:0] core_mem_addr = 8'h00;
  logic [7:0] core_mem_data;
  logic       fifo_write, fifo_read;
  logic [7:0] fifo_wdata;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_empty = 1'b1;

  useq_host_bridge dut (
    .clk(clk), .rst_n(rst_n), .host(bus),
    .core_rst_n(core_rst_n), .core_mem_addr(core_mem_addr), .core_mem_data(core_mem_data),
    .fifo_write(fifo_write), .fifo_wdata(fifo_wdata), .fifo_read(fifo_read),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] model_ram [256];
  bit         model_known [256];
  bit         model_halted = 1'b1;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_fifo[$];
  logic [7:0] core_q[$];
  int         wr_pulses = 0;
  int         rd_pulses = 0;
  logic [7:0] last_wdata = 8'h00;
  logic [7:0] last_tx = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Stand-in for the core's FIFO: registered read data, popped on read_fifo
  always @(posedge clk) begin
    if (fifo_write) begin
      core_q.push_back(fifo_wdata);
      wr_pulses++;
      last_wdata = fifo_wdata;
    end
    if (fifo_read) begin
      rd_pulses++;
      if (core_q.size() > 0) fifo_rdata <= core_q.pop_front();
    end
    fifo_empty <= (core_q.size() == 0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (model_known[core_mem_addr]) check("ram_read", core_mem_data, model_ram[core_mem_addr]);
      check("pulse_excl", 32'(fifo_write & fifo_read), 0);
      if (model_halted) check("pulse_halted", 32'(fifo_write | fifo_read), 0);
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) check("tx_extra", 1, 0);
        else check("tx_byte", bus.tx_data, exp_tx.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bit done = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.rx_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    bus.rx_valid = 1'b0;
    if (!done) check("rx_timeout", 0, 1);
  endtask

  task automatic take(input int hold);
    logic [7:0] d;
    int n = 0;
    @(negedge clk);
    while (!bus.tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_valid) begin
      check("tx_timeout", 0, 1);
    end else begin
      d = bus.tx_data;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("tx_hold", {bus.tx_valid, bus.rx_ready, bus.tx_data}, {1'b1, 1'b0, d});
      end
      last_tx = bus.tx_data;
      @(posedge clk);
      #1 bus.tx_ready = 1'b1;
      @(posedge clk);
      #1 bus.tx_ready = 1'b0;
    end
  endtask

  function automatic logic [7:0] expect_reply(input logic [7:0] b);
    case (b)
      8'h47: begin model_halted = 1'b0; return 8'h4B; end
      8'h48: begin model_halted = 1'b1; return 8'h4B; end
      8'h57: return model_halted ? 8'h21 : 8'h00;
      8'h52: begin
        if (model_halted) return 8'h21;
        if (exp_fifo.size() == 0) return 8'h00;
        return exp_fifo.pop_front();
      end
      8'h53: return {6'b0, model_halted, exp_fifo.size() == 0};
      default: return 8'h3F;
    endcase
  endfunction

  task automatic cmd(input logic [7:0] b, input int hold);
    exp_tx.push_back(expect_reply(b));
    send(b);
    take(hold);
  endtask

  task automatic load_bytes(input logic [7:0] a, input logic [7:0] n, input logic [7:0] data[$], input bit finish);
    logic [7:0] p = a;
    if (finish) exp_tx.push_back(8'h4B);
    model_halted = 1'b1;
    send(8'h4C);
    send(a);
    send(n);
    foreach (data[i]) begin
      send(data[i]);
      model_ram[p]   = data[i];
      model_known[p] = 1'b1;
      p++;
    end
    if (finish) take(0);
  endtask

  task automatic write_fifo(input logic [7:0] v);
    exp_tx.push_back(8'h4B);
    exp_fifo.push_back(v);
    send(8'h57);
    send(v);
    take(0);
  endtask

  task automatic read_cmd(input bool_latency);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[$];
    int w0, r0, lat;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {bus.tx_valid, bus.tx_data, core_rst_n, fifo_write, fifo_read, fifo_wdata},
          {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
    check("rst_rx_ready", bus.rx_ready, 1);
    rst_n = 1'b1;

    d = '{8'hA1, 8'hB2, 8'hC3};
    load_bytes(8'h00, 8'h03, d, 1'b1);
    check("load_ack", last_tx, 8'h4B);
    check("load_core_held", core_rst_n, 0);
    core_mem_addr = 8'h01;
    #1 check("ram_1", core_mem_data, 8'hB2);

    d = '{8'h01, 8'h02, 8'h03};
    load_bytes(8'hFE, 8'h03, d, 1'b1);
    core_mem_addr = 8'hFE; #1 check("ram_fe", core_mem_data, 8'h01);
    core_mem_addr = 8'hFF; #1 check("ram_ff", core_mem_data, 8'h02);
    core_mem_addr = 8'h00; #1 check("ram_00", core_mem_data, 8'h03);

    d = {};
    for (int i = 0; i < 256; i++) d.push_back(8'(i) ^ 8'h5C);
    load_bytes(8'h10, 8'h00, d, 1'b1);
    repeat (3) @(negedge clk);
    check("full_single_ack", {bus.tx_valid, 24'(exp_tx.size())}, 0);
    for (int a = 0; a < 256; a++) begin
      @(posedge clk);
      #1 core_mem_addr = 8'(a);
    end
    core_mem_addr = 8'h10; #1 check("ram_10", core_mem_data, 8'h5C);
    core_mem_addr = 8'h0F; #1 check("ram_0f", core_mem_data, 8'hA3);

    w0 = wr_pulses;
    cmd(8'h57, 0);
    check("w_halted_err", last_tx, 8'h21);
    cmd(8'h5A, 0);
    check("w_data_as_cmd", last_tx, 8'h3F);
    check("w_halted_no_pulse", wr_pulses, w0);

    model_halted = 1'b0;
    exp_tx.push_back(8'h4B);
    send(8'h47);
    check("g_rst_lag", core_rst_n, 0);
    @(posedge clk);
    #1 check("g_rst_release", core_rst_n, 1);
    take(0);

    w0 = wr_pulses;
    write_fifo(8'h77);
    check("w_pulse_count", wr_pulses - w0, 1);
    check("w_wdata", last_wdata, 8'h77);

    r0 = rd_pulses;
    exp_tx.push_back(expect_reply(8'h52));
    send(8'h52);
    lat = 1;
    while (!bus.tx_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("r_latency", lat, 3);
    take(0);
    check("r_data", last_tx, 8'h77);
    check("r_pulse_count", rd_pulses - r0, 1);
    cmd(8'h52, 0);
    check("r_empty", last_tx, 8'h00);
    check("r_empty_no_pulse", rd_pulses - r0, 1);
    cmd(8'h53, 0);
    check("status_run_empty", last_tx, 8'h01);

    cmd(8'h53, 10);

    model_halted = 1'b1;
    send(8'h4C);
    check("l_rst_lag", core_rst_n, 1);
    @(posedge clk);
    #1 check("l_rst_fall", core_rst_n, 0);
    send(8'h40);
    send(8'h05);
    send(8'hDE); model_ram[8'h40] = 8'hDE; model_known[8'h40] = 1'b1;
    send(8'hAD); model_ram[8'h41] = 8'hAD; model_known[8'h41] = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midload_rst", {bus.tx_valid, core_rst_n, bus.rx_ready}, {1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;
    core_mem_addr = 8'h40; #1 check("ram_40_kept", core_mem_data, 8'hDE);
    core_mem_addr = 8'h41; #1 check("ram_41_kept", core_mem_data, 8'hAD);
    cmd(8'h53, 0);
    check("status_after_rst", last_tx, {6'b0, 1'b1, fifo_empty});

    repeat (4) @(negedge clk);
    check("tx_missing", exp_tx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
